// File: rtl/cache_replacement_unit.sv
// Per-set replacement-state engine: true-LRU or tree-PLRU, self-timed init sweep, RMW forwarding.
// Optional feature macro: REPL_INVALID_PREF_EN (prefer lowest invalid way as victim).
module cache_replacement_unit #(
    parameter int unsigned NUM_WAYS   = 4,
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned POLICY     = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    output logic                        ready,
    input  logic                        touch_valid,
    input  logic [INDEX_BITS-1:0]       touch_index,
    input  logic [$clog2(NUM_WAYS)-1:0] touch_way,
    input  logic                        lookup_valid,
    input  logic [INDEX_BITS-1:0]       lookup_index,
    input  logic [NUM_WAYS-1:0]         valid_mask,
    output logic                        victim_valid,
    output logic [$clog2(NUM_WAYS)-1:0] victim_way,
    output logic [NUM_WAYS-1:0]         victim_onehot
);
    localparam int unsigned WB    = $clog2(NUM_WAYS);
    localparam int unsigned DEPTH = 2 ** INDEX_BITS;
    localparam int unsigned SW    = (POLICY == 1) ? NUM_WAYS - 1 : NUM_WAYS * WB;

    typedef enum logic {INIT, RUN} state_t;
    state_t state, state_next;

    logic [INDEX_BITS-1:0] init_ptr;
    logic [SW-1:0]         mem [DEPTH];
    logic                  wr_en;
    logic [INDEX_BITS-1:0] wr_index;
    logic [SW-1:0]         wr_data;
    logic                  t1_valid, l1_valid;
    logic [WB-1:0]         t1_way;
    logic [INDEX_BITS-1:0] t1_index;
    logic [SW-1:0]         t1_state, l1_state;
    logic [SW-1:0]         touched_state, init_state;
    logic [WB-1:0]         policy_victim, sel;

    always_ff @(posedge clock) begin
        if (reset) state <= INIT;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        if (state == INIT && init_ptr == '1) state_next = RUN;
    end

    // Sweep owns the write port during INIT; reset suppresses any in-flight RMW write.
    always_comb begin
        ready = (state == RUN);
        if (state == INIT) begin
            wr_en    = !reset;
            wr_index = init_ptr;
            wr_data  = init_state;
        end else begin
            wr_en    = t1_valid && !reset;
            wr_index = t1_index;
            wr_data  = touched_state;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)              init_ptr <= '0;
        else if (state == INIT) init_ptr <= init_ptr + INDEX_BITS'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            t1_valid <= 1'b0;
            l1_valid <= 1'b0;
        end else begin
            t1_valid <= touch_valid && ready;
            l1_valid <= lookup_valid && ready;
        end
    end

    // Reads bypass the array when the write landing on the same edge targets the same set.
    always_ff @(posedge clock) begin
        t1_way   <= touch_way;
        t1_index <= touch_index;
        t1_state <= (wr_en && wr_index == touch_index) ? wr_data : mem[touch_index];
        l1_state <= (wr_en && wr_index == lookup_index) ? wr_data : mem[lookup_index];
        if (wr_en) mem[wr_index] <= wr_data;
    end

    generate
        if (POLICY == 1) begin : g_plru
            // Heap nodes 1..NUM_WAYS-1; leaf for way w is node NUM_WAYS+w.
            always_comb begin
                logic [NUM_WAYS-1:1] nxt, rd;
                logic                match;
                int unsigned         leaf;
                nxt = t1_state;
                leaf = NUM_WAYS + 32'(t1_way);
                for (int unsigned s = 1; s <= WB; s++) begin
                    nxt[WB'(leaf >> s)] = ((leaf >> (s - 1)) & 1) == 0;
                end
                touched_state = nxt;
                rd = l1_state;
                policy_victim = '0;
                for (int unsigned w = 0; w < NUM_WAYS; w++) begin
                    match = 1'b1;
                    leaf = NUM_WAYS + w;
                    for (int unsigned s = 1; s <= WB; s++) begin
                        if (rd[WB'(leaf >> s)] != (((leaf >> (s - 1)) & 1) != 0)) match = 1'b0;
                    end
                    if (match) policy_victim = WB'(w);
                end
                init_state = '0;
            end
        end else begin : g_lru
            typedef logic [NUM_WAYS-1:0][WB-1:0] age_t;
            always_comb begin
                age_t cur, nxt, rd, ini;
                cur = age_t'(t1_state);
                nxt = cur;
                rd  = age_t'(l1_state);
                policy_victim = '0;
                for (int unsigned i = 0; i < NUM_WAYS; i++) begin
                    if (WB'(i) == t1_way)
                        nxt[WB'(i)] = '0;
                    else if (cur[WB'(i)] < cur[t1_way])
                        nxt[WB'(i)] = cur[WB'(i)] + WB'(1);
                    if (rd[WB'(i)] == WB'(NUM_WAYS - 1)) policy_victim = WB'(i);
                    ini[WB'(i)] = WB'(i);
                end
                touched_state = nxt;
                init_state    = ini;
            end
        end
    endgenerate

`ifdef REPL_INVALID_PREF_EN
    logic [NUM_WAYS-1:0] l1_mask;
    always_ff @(posedge clock) l1_mask <= valid_mask;

    always_comb begin
        logic found;
        found = 1'b0;
        sel   = policy_victim;
        for (int unsigned i = 0; i < NUM_WAYS; i++) begin
            if (!found && !l1_mask[WB'(i)]) begin
                sel   = WB'(i);
                found = 1'b1;
            end
        end
    end
`else
    logic unused_valid_mask;
    assign unused_valid_mask = ^valid_mask;
    assign sel = policy_victim;
`endif

    always_comb begin
        victim_valid  = l1_valid;
        victim_way    = l1_valid ? sel : '0;
        victim_onehot = l1_valid ? (NUM_WAYS'(1) << sel) : '0;
    end
endmodule

// File: tb/tb_cache_replacement_unit.sv
// Bench for cache_replacement_unit: LRU and PLRU instances side by side, vector table plus random traffic.
module tb_cache_replacement_unit;
    localparam int W = 4;
    localparam int IB = 2;
    localparam int DEPTH = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          touch_valid = 1'b0, lookup_valid = 1'b0;
    logic [IB-1:0] touch_index = '0, lookup_index = '0;
    logic [1:0]    touch_way = '0;
    logic [W-1:0]  valid_mask = '1;
    logic          ready_l, ready_p, victim_valid_l, victim_valid_p;
    logic [1:0]    victim_way_l, victim_way_p;
    logic [W-1:0]  victim_onehot_l, victim_onehot_p;

    cache_replacement_unit #(.NUM_WAYS(W), .INDEX_BITS(IB), .POLICY(0)) dut_lru (
        .clock(clock), .reset(reset), .ready(ready_l),
        .touch_valid(touch_valid), .touch_index(touch_index), .touch_way(touch_way),
        .lookup_valid(lookup_valid), .lookup_index(lookup_index), .valid_mask(valid_mask),
        .victim_valid(victim_valid_l), .victim_way(victim_way_l), .victim_onehot(victim_onehot_l));

    cache_replacement_unit #(.NUM_WAYS(W), .INDEX_BITS(IB), .POLICY(1)) dut_plru (
        .clock(clock), .reset(reset), .ready(ready_p),
        .touch_valid(touch_valid), .touch_index(touch_index), .touch_way(touch_way),
        .lookup_valid(lookup_valid), .lookup_index(lookup_index), .valid_mask(valid_mask),
        .victim_valid(victim_valid_p), .victim_way(victim_way_p), .victim_onehot(victim_onehot_p));

    always #5 clock = ~clock;

`ifdef REPL_INVALID_PREF_EN
    localparam bit PREF = 1'b1;
`else
    localparam bit PREF = 1'b0;
`endif

    typedef struct {
        int tv, ti, tw, lv, li, mask, exp_lru, exp_plru;
    } vec_t;

    int errors = 0;
    int checks = 0;
    int init_left = 0;
    int lru_q [DEPTH][$];   // recency list per set, MRU first
    bit plru_bits [DEPTH][W];
    vec_t vecs [17];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_init();
        for (int s = 0; s < DEPTH; s++) begin
            lru_q[s].delete();
            for (int i = 0; i < W; i++) begin
                lru_q[s].push_back(i);
                plru_bits[s][i] = 1'b0;
            end
        end
    endtask

    task automatic model_touch(input int s, input int a);
        int lo, n, node;
        for (int i = 0; i < lru_q[s].size(); i++) begin
            if (lru_q[s][i] == a) begin
                lru_q[s].delete(i);
                break;
            end
        end
        lru_q[s].push_front(a);
        lo = 0; n = W; node = 1;
        while (n > 1) begin
            n = n / 2;
            if (a >= lo + n) begin
                plru_bits[s][node] = 1'b0;
                lo = lo + n;
                node = 2 * node + 1;
            end else begin
                plru_bits[s][node] = 1'b1;
                node = 2 * node;
            end
        end
    endtask

    function automatic int model_victim(input int pol, input int s, input logic [W-1:0] m);
        int lo, n, node;
        if (PREF && m != '1) begin
            for (int i = 0; i < W; i++) if (!m[i]) return i;
        end
        if (pol == 0) return lru_q[s][lru_q[s].size() - 1];
        lo = 0; n = W; node = 1;
        while (n > 1) begin
            n = n / 2;
            if (plru_bits[s][node]) begin
                lo = lo + n;
                node = 2 * node + 1;
            end else begin
                node = 2 * node;
            end
        end
        return lo;
    endfunction

    task automatic do_reset();
        reset = 1'b1;
        touch_valid = 1'b0;
        lookup_valid = 1'b0;
        @(posedge clock); #1;
        check("rst_ready_lru", 32'(ready_l), 0);
        check("rst_ready_plru", 32'(ready_p), 0);
        check("rst_vvalid_lru", 32'(victim_valid_l), 0);
        check("rst_vvalid_plru", 32'(victim_valid_p), 0);
        check("rst_vway_lru", 32'(victim_way_l), 0);
        check("rst_vway_plru", 32'(victim_way_p), 0);
        check("rst_onehot_lru", 32'(victim_onehot_l), 0);
        check("rst_onehot_plru", 32'(victim_onehot_p), 0);
        model_init();
        init_left = DEPTH;
        reset = 1'b0;
        check("init_ready_c0", 32'(ready_l & ready_p), 0);
    endtask

    task automatic cycle(input int tv, input int ti, input int tw, input int lv, input int li,
                         input logic [W-1:0] m, input bit use_tab, input int tab_lru, input int tab_plru);
        bit acc, exp_v;
        int el, ep;
        touch_valid  = (tv != 0);
        touch_index  = IB'(ti);
        touch_way    = 2'(tw);
        lookup_valid = (lv != 0);
        lookup_index = IB'(li);
        valid_mask   = m;
        acc   = (init_left == 0);
        exp_v = acc && (lv != 0);
        el = 0; ep = 0;
        if (exp_v) begin
            if (use_tab) begin
                el = tab_lru;
                ep = tab_plru;
            end else begin
                el = model_victim(0, li, m);
                ep = model_victim(1, li, m);
            end
        end
        if (acc && tv != 0) model_touch(ti, tw);
        @(posedge clock); #1;
        if (init_left > 0) init_left--;
        check("ready_lru", 32'(ready_l), 32'(init_left == 0));
        check("ready_plru", 32'(ready_p), 32'(init_left == 0));
        check("vvalid_lru", 32'(victim_valid_l), 32'(exp_v));
        check("vvalid_plru", 32'(victim_valid_p), 32'(exp_v));
        if (exp_v) begin
            check("vway_lru", 32'(victim_way_l), el);
            check("vway_plru", 32'(victim_way_p), ep);
            check("onehot_lru", 32'(victim_onehot_l), 32'(1) << el);
            check("onehot_plru", 32'(victim_onehot_p), 32'(1) << ep);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        //          tv ti tw lv li mask  lru  plru
        vecs[0]  = '{0, 0, 0, 1, 0, 15,  3,   0};
        vecs[1]  = '{1, 1, 3, 0, 0, 15,  0,   0};
        vecs[2]  = '{1, 1, 2, 0, 0, 15,  0,   0};
        vecs[3]  = '{1, 1, 1, 0, 0, 15,  0,   0};
        vecs[4]  = '{1, 1, 0, 0, 0, 15,  0,   0};
        vecs[5]  = '{0, 0, 0, 1, 1, 15,  3,   3};
        vecs[6]  = '{1, 1, 3, 0, 0, 15,  0,   0};
        vecs[7]  = '{0, 0, 0, 1, 1, 15,  2,   1};
        vecs[8]  = '{1, 2, 0, 0, 0, 15,  0,   0};
        vecs[9]  = '{0, 0, 0, 1, 2, 15,  3,   2};
        vecs[10] = '{1, 2, 2, 0, 0, 15,  0,   0};
        vecs[11] = '{0, 0, 0, 1, 2, 15,  3,   1};
        vecs[12] = '{1, 0, 3, 1, 0, 15,  3,   0};
        vecs[13] = '{0, 0, 0, 1, 0, 15,  2,   0};
        vecs[14] = '{0, 0, 0, 0, 0, 15,  0,   0};
        vecs[15] = '{0, 0, 0, 1, 0, 11,  2,   PREF ? 2 : 0};
        vecs[16] = '{0, 0, 0, 1, 1,  6,  PREF ? 0 : 2, PREF ? 0 : 1};

        do_reset();
        for (int k = 0; k < DEPTH; k++) cycle(0, 0, 0, 0, 0, '1, 1'b0, 0, 0);

        for (int i = 0; i < 17; i++)
            cycle(vecs[i].tv, vecs[i].ti, vecs[i].tw, vecs[i].lv, vecs[i].li,
                  W'(vecs[i].mask), 1'b1, vecs[i].exp_lru, vecs[i].exp_plru);

        for (int i = 0; i < 400; i++) begin
            logic [W-1:0] m;
            m = ($urandom_range(0, 3) == 0) ? W'($urandom) : '1;
            cycle(int'($urandom_range(0, 1)), int'($urandom_range(0, DEPTH - 1)),
                  int'($urandom_range(0, W - 1)), int'($urandom_range(0, 1)),
                  int'($urandom_range(0, DEPTH - 1)), m, 1'b0, 0, 0);
        end

        // Reset landing mid-sweep (init_ptr=2), with requests offered during the restarted sweep.
        do_reset();
        cycle(0, 0, 0, 0, 0, '1, 1'b0, 0, 0);
        cycle(0, 0, 0, 0, 0, '1, 1'b0, 0, 0);
        do_reset();
        for (int k = 0; k < DEPTH; k++) cycle(1, 1, k % W, 1, 1, '1, 1'b0, 0, 0);
        cycle(0, 0, 0, 1, 1, '1, 1'b1, 3, 0);
        cycle(0, 0, 0, 1, 0, '1, 1'b1, 3, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
